// File: rtl/mw_pkg.sv
// Constants and helpers shared by the keypad/button conditioning logic.
package mw_pkg;

    localparam int KEY_COUNT         = 10;
    localparam int DIGIT_W           = 4;
    localparam int DB_CYCLES_DEFAULT = 4;

    typedef struct packed {
        logic start;
        logic stop;
        logic clear;
    } cmd_t;

    // Lowest-index set bit wins when several keys are down together.
    function automatic logic [DIGIT_W-1:0] lowest_key(input logic [KEY_COUNT-1:0] v);
        lowest_key = '0;
        for (int i = KEY_COUNT - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_key = DIGIT_W'(i);
            end
        end
    endfunction

    function automatic logic is_one_hot(input logic [KEY_COUNT-1:0] v);
        return (v != '0) && ((v & (v - KEY_COUNT'(1))) == '0);
    endfunction

endpackage

// File: rtl/kbd_conditioner_debounce.sv
// Two-flop synchronizer followed by a vector debouncer: the stable value
// adopts a new sample only after it has been identical for DB_CYCLES cycles.
module debounce
    import mw_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_stable
);

    localparam logic [7:0] CNT_TARGET = 8'(DB_CYCLES);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_stable;
    logic [7:0]       r_cnt;

    logic [7:0] w_base;
    logic [7:0] w_next;
    logic       w_hit;

    // A sample that differs from the previous one restarts the run at one.
    always_comb begin
        w_base = (r_sync2 == r_cand) ? r_cnt : 8'd0;
        w_next = w_base + 8'd1;
        w_hit  = (w_next == CNT_TARGET);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= RST_VAL;
            r_sync2  <= RST_VAL;
            r_cand   <= RST_VAL;
            r_stable <= RST_VAL;
            r_cnt    <= 8'd0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_cand  <= r_sync2;
            if (r_sync2 == r_stable) begin
                r_cnt <= 8'd0;
            end else if (w_hit) begin
                r_stable <= r_sync2;
                r_cnt    <= 8'd0;
            end else begin
                r_cnt <= w_next;
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/kbd_conditioner.sv
// Keypad, command-button and door-switch conditioner: synchronize, debounce,
// and turn presses into one-cycle strobes. Option: KBD_MULTI_KEY_REJECT_EN.
module kbd_conditioner
    import mw_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [KEY_COUNT-1:0] kbd,
    input  logic                 startn,
    input  logic                 stopn,
    input  logic                 clearn,
    input  logic                 door_closed,
    output logic [DIGIT_W-1:0]   digit,
    output logic                 digit_valid,
    output logic                 start_pulse,
    output logic                 stop_pulse,
    output logic                 clear_pulse,
    output logic                 door_closed_db
);

    logic [KEY_COUNT-1:0] w_kbd_db;
    logic                 w_startn_db;
    logic                 w_stopn_db;
    logic                 w_clearn_db;
    logic                 w_door_db;

    debounce #(.WIDTH(KEY_COUNT), .DB_CYCLES(DB_CYCLES), .RST_VAL('0)) u_db_kbd (
        .clk(clk), .rst(rst), .i_raw(kbd), .o_stable(w_kbd_db)
    );

    debounce #(.WIDTH(1), .DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_db_start (
        .clk(clk), .rst(rst), .i_raw(startn), .o_stable(w_startn_db)
    );

    debounce #(.WIDTH(1), .DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_db_stop (
        .clk(clk), .rst(rst), .i_raw(stopn), .o_stable(w_stopn_db)
    );

    debounce #(.WIDTH(1), .DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_db_clear (
        .clk(clk), .rst(rst), .i_raw(clearn), .o_stable(w_clearn_db)
    );

    debounce #(.WIDTH(1), .DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_db_door (
        .clk(clk), .rst(rst), .i_raw(door_closed), .o_stable(w_door_db)
    );

    logic                 r_key_lock;
    logic [DIGIT_W-1:0]   r_digit;
    logic                 r_digit_valid;
    cmd_t                 r_pressed_prev;
    cmd_t                 r_pulse;
    logic                 r_door_db;

    cmd_t w_pressed;
    cmd_t w_edge;
    logic w_key_press;
    logic w_key_accept;

    // The lock follows the stable vector, so only a 0 -> nonzero step strobes.
    always_comb begin
        w_pressed.start = ~w_startn_db;
        w_pressed.stop  = ~w_stopn_db;
        w_pressed.clear = ~w_clearn_db;
        w_edge          = w_pressed & ~r_pressed_prev;
        w_key_press     = (|w_kbd_db) & ~r_key_lock;
`ifdef KBD_MULTI_KEY_REJECT_EN
        w_key_accept    = w_key_press & is_one_hot(w_kbd_db);
`else
        w_key_accept    = w_key_press;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_lock     <= 1'b0;
            r_digit        <= '0;
            r_digit_valid  <= 1'b0;
            r_pressed_prev <= '0;
            r_pulse        <= '0;
            r_door_db      <= 1'b0;
        end else begin
            r_key_lock     <= |w_kbd_db;
            r_digit_valid  <= w_key_accept;
            if (w_key_accept) begin
                r_digit <= lowest_key(w_kbd_db);
            end
            r_pressed_prev <= w_pressed;
            r_pulse.stop   <= w_edge.stop;
            r_pulse.clear  <= w_edge.clear;
            r_pulse.start  <= w_edge.start & ~w_edge.stop & ~w_edge.clear;
            r_door_db      <= w_door_db;
        end
    end

    assign digit          = r_digit;
    assign digit_valid    = r_digit_valid;
    assign start_pulse    = r_pulse.start;
    assign stop_pulse     = r_pulse.stop;
    assign clear_pulse    = r_pulse.clear;
    assign door_closed_db = r_door_db;

endmodule

// File: tb/tb_kbd_conditioner.sv
// Directed bench for kbd_conditioner with a window-based reference model
// checked every cycle, plus literal latency/count expectations per scenario.
module tb_kbd_conditioner;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] kbd;
    logic       startn, stopn, clearn, door_closed;
    logic [3:0] digit;
    logic       digit_valid, start_pulse, stop_pulse, clear_pulse, door_closed_db;

    kbd_conditioner #(.DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .kbd(kbd),
        .startn(startn), .stopn(stopn), .clearn(clearn), .door_closed(door_closed),
        .digit(digit), .digit_valid(digit_valid),
        .start_pulse(start_pulse), .stop_pulse(stop_pulse), .clear_pulse(clear_pulse),
        .door_closed_db(door_closed_db)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: index 0 = kbd, 1 = startn, 2 = stopn, 3 = clearn, 4 = door.
    logic [9:0] m_d1[5], m_d2[5], m_cur[5], m_last[5];
    logic [9:0] m_win[5][DB];
    int         m_fill[5];
    logic [3:0] m_digit;
    logic       e_dv, e_start, e_stop, e_clear, e_door;

    // Scenario statistics taken from the DUT outputs.
    int t_edge, dv_cnt, dv_first, start_cnt, start_first, stop_cnt, stop_first;
    int clear_cnt, clear_first, door_hi, door_first;
    logic [3:0] dv_digit;

    function automatic logic [9:0] rst_val(input int s);
        return (s >= 1 && s <= 3) ? 10'd1 : 10'd0;
    endfunction

    function automatic int count_ones(input logic [9:0] v);
        int c = 0;
        for (int i = 0; i < 10; i++) if (v[i]) c++;
        return c;
    endfunction

    function automatic logic [3:0] low_idx(input logic [9:0] v);
        logic [3:0] r = 4'd0;
        logic       found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (v[i] && !found) begin
                r = 4'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic void model_edge();
        logic [9:0] raw[5];
        logic [9:0] old_v[5];
        logic [9:0] older_v[5];
        logic [9:0] seen;
        logic       same;
        logic       st_e, sp_e, cl_e, accept;
        raw[0] = kbd;
        raw[1] = {9'd0, startn};
        raw[2] = {9'd0, stopn};
        raw[3] = {9'd0, clearn};
        raw[4] = {9'd0, door_closed};
        if (rst) begin
            for (int s = 0; s < 5; s++) begin
                m_d1[s] = rst_val(s); m_d2[s] = rst_val(s);
                m_cur[s] = rst_val(s); m_last[s] = rst_val(s);
                m_fill[s] = 0;
            end
            m_digit = 4'd0;
            e_dv = 1'b0; e_start = 1'b0; e_stop = 1'b0; e_clear = 1'b0; e_door = 1'b0;
            return;
        end
        for (int s = 0; s < 5; s++) begin
            seen = m_d2[s];
            m_d2[s] = m_d1[s];
            m_d1[s] = raw[s];
            for (int k = DB - 1; k > 0; k--) m_win[s][k] = m_win[s][k-1];
            m_win[s][0] = seen;
            if (m_fill[s] < DB) m_fill[s]++;
            old_v[s] = m_cur[s];
            older_v[s] = m_last[s];
            m_last[s] = m_cur[s];
            same = 1'b1;
            for (int k = 0; k < DB; k++) if (m_win[s][k] != seen) same = 1'b0;
            if (m_fill[s] == DB && same && seen != m_cur[s]) m_cur[s] = seen;
        end
`ifdef KBD_MULTI_KEY_REJECT_EN
        accept = (count_ones(old_v[0]) == 1);
`else
        accept = 1'b1;
`endif
        e_dv = (old_v[0] != 10'd0) && (older_v[0] == 10'd0) && accept;
        if (e_dv) m_digit = low_idx(old_v[0]);
        st_e = (old_v[1][0] == 1'b0) && (older_v[1][0] == 1'b1);
        sp_e = (old_v[2][0] == 1'b0) && (older_v[2][0] == 1'b1);
        cl_e = (old_v[3][0] == 1'b0) && (older_v[3][0] == 1'b1);
        e_stop  = sp_e;
        e_clear = cl_e;
        e_start = st_e && !sp_e && !cl_e;
        e_door  = old_v[4][0];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic test_begin();
        t_edge = 0; dv_cnt = 0; dv_first = 0; dv_digit = 4'd0;
        start_cnt = 0; start_first = 0; stop_cnt = 0; stop_first = 0;
        clear_cnt = 0; clear_first = 0; door_hi = 0; door_first = 0;
    endtask

    // One clock: update the model, compare every output, gather statistics.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            model_edge();
            chk("digit_valid", int'(digit_valid), int'(e_dv));
            chk("start_pulse", int'(start_pulse), int'(e_start));
            chk("stop_pulse", int'(stop_pulse), int'(e_stop));
            chk("clear_pulse", int'(clear_pulse), int'(e_clear));
            chk("door_closed_db", int'(door_closed_db), int'(e_door));
            if (e_dv || rst) chk("digit", int'(digit), int'(m_digit));
            t_edge++;
            if (digit_valid) begin
                dv_cnt++;
                if (dv_first == 0) begin dv_first = t_edge; dv_digit = digit; end
            end
            if (start_pulse) begin start_cnt++; if (start_first == 0) start_first = t_edge; end
            if (stop_pulse)  begin stop_cnt++;  if (stop_first == 0)  stop_first = t_edge;  end
            if (clear_pulse) begin clear_cnt++; if (clear_first == 0) clear_first = t_edge; end
            if (door_closed_db) begin door_hi++; if (door_first == 0) door_first = t_edge; end
        end
    endtask

    initial begin
        rst = 1'b1; kbd = 10'd0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1; door_closed = 1'b0;
        test_begin();
        step(3);
        chk("reset_digit", int'(digit), 0);
        chk("reset_outputs", int'({digit_valid, start_pulse, stop_pulse, clear_pulse, door_closed_db}), 0);
        rst = 1'b0;
        step(4);

        // Single key held 20 cycles, then released.
        test_begin();
        kbd = 10'b0000000010;
        step(20);
        chk("key1_count", dv_cnt, 1);
        chk("key1_edge", dv_first, 7);
        chk("key1_digit", int'(dv_digit), 1);
        kbd = 10'd0;
        step(10);
        chk("key1_no_release_strobe", dv_cnt, 1);

        // Short start glitch, then a real press.
        test_begin();
        startn = 1'b0; step(2);
        startn = 1'b1; step(12);
        chk("start_glitch", start_cnt, 0);
        test_begin();
        startn = 1'b0; step(10);
        startn = 1'b1; step(10);
        chk("start_count", start_cnt, 1);
        chk("start_edge", start_first, 7);

        // Start and stop together: stop wins.
        test_begin();
        startn = 1'b0; stopn = 1'b0; step(12);
        chk("ss_stop_count", stop_cnt, 1);
        chk("ss_stop_edge", stop_first, 7);
        chk("ss_start_suppressed", start_cnt, 0);
        startn = 1'b1; stopn = 1'b1; step(10);
        chk("ss_no_release_pulse", start_cnt + stop_cnt, 1);

        // Two keys at once.
        test_begin();
        kbd = 10'b1000000100; step(12);
`ifdef KBD_MULTI_KEY_REJECT_EN
        chk("multi_reject", dv_cnt, 0);
`else
        chk("multi_count", dv_cnt, 1);
        chk("multi_digit", int'(dv_digit), 2);
`endif
        kbd = 10'd0; step(10);

        // Second key added while first is held is ignored.
        test_begin();
        kbd = 10'b0000001000; step(10);
        kbd = 10'b0000011000; step(10);
        chk("lock_count", dv_cnt, 1);
        chk("lock_digit", int'(dv_digit), 3);
        kbd = 10'd0; step(10);

        // Door chatter then steady closed.
        test_begin();
        for (int i = 0; i < 20; i++) begin
            door_closed = (i % 2 == 0);
            step(1);
        end
        chk("door_chatter", door_hi, 0);
        test_begin();
        door_closed = 1'b1; step(12);
        chk("door_edge", door_first, 7);
        door_closed = 1'b0; step(10);

        // Clear with start and a key: clear wins, key strobes alongside.
        test_begin();
        kbd = 10'b0000000001; clearn = 1'b0; startn = 1'b0; step(12);
        chk("cs_clear_count", clear_cnt, 1);
        chk("cs_start_suppressed", start_cnt, 0);
        chk("cs_clear_edge", clear_first, 7);
        chk("cs_key_edge", dv_first, 7);
        kbd = 10'd0; clearn = 1'b1; startn = 1'b1; step(10);

        // Stop and clear together both pulse.
        test_begin();
        stopn = 1'b0; clearn = 1'b0; step(12);
        chk("sc_stop_edge", stop_first, 7);
        chk("sc_clear_edge", clear_first, 7);
        stopn = 1'b1; clearn = 1'b1; step(10);

        // Vector changes mid-count restart the debounce.
        test_begin();
        kbd = 10'b0000000100; step(3);
        kbd = 10'b0000001000; step(12);
        chk("restart_edge", dv_first, 10);
        chk("restart_digit", int'(dv_digit), 3);
        kbd = 10'd0; step(10);

        // Reset at debounce count 3 with key 9 held.
        kbd = 10'b1000000000; step(5);
        rst = 1'b1; step(1);
        chk("midreset_outputs", int'({digit_valid, start_pulse, stop_pulse, clear_pulse, door_closed_db}), 0);
        rst = 1'b0;
        test_begin();
        step(12);
        chk("midreset_count", dv_cnt, 1);
        chk("midreset_edge", dv_first, 7);
        chk("midreset_digit", int'(dv_digit), 9);
        kbd = 10'd0; step(10);

        // Start held across reset release.
        rst = 1'b1; startn = 1'b0; step(3);
        rst = 1'b0;
        test_begin();
        step(12);
        chk("held_reset_count", start_cnt, 1);
        chk("held_reset_edge", start_first, 7);
        startn = 1'b1; step(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/kbd_conditioner.md
KBD_CONDITIONER -- requirements
Module: kbd_conditioner

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4, meaning consecutive stable cycles required before a debounced value changes (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port kbd, input, 10, raw keypad; bit i high = digit i pressed.
REQ-005 SHALL have ports startn, stopn, clearn, input, 1 each, raw buttons, active-low.
REQ-006 SHALL have port door_closed, input, 1, raw door switch; high = closed.
REQ-007 SHALL have port digit, output, 4, BCD of the last accepted key.
REQ-008 SHALL have port digit_valid, output, 1, one-cycle strobe qualifying digit.
REQ-009 SHALL have ports start_pulse, stop_pulse, clear_pulse, output, 1 each, one-cycle active-high command strobes.
REQ-010 SHALL have port door_closed_db, output, 1, debounced door level.

Function
REQ-011 SHALL pass every raw input through a 2-flop synchronizer before any other logic.
REQ-012 SHALL debounce each synchronized signal: the stable value takes the sampled value only after DB_CYCLES consecutive cycles of disagreement with it. Any cycle of agreement clears the counter.
REQ-013 SHALL debounce kbd as one 10-bit vector: the stable vector updates only after the sampled vector is unchanged and different for DB_CYCLES cycles.
REQ-014 SHALL detect a key press on a stable-vector transition from zero to nonzero. It then drives digit = encoded index and pulses digit_valid for exactly one cycle.
REQ-015 SHALL lock after a press: no further digit_valid until the stable vector returns to all-zero. A second key added while one is held is ignored.
REQ-016 SHALL hold digit between strobes; digit is only meaningful when digit_valid is high.
REQ-017 SHALL pulse start_pulse, stop_pulse and clear_pulse for one cycle on the released-to-pressed transition of the respective debounced button. There is no pulse on release and no repeat while held.
REQ-018 SHALL give priority on simultaneous events: clear_pulse or stop_pulse in the same cycle suppresses start_pulse. Stop and clear may pulse together.
REQ-019 SHALL treat key and button paths as independent; digit_valid and command pulses may coincide.
REQ-020 SHALL have a latency of exactly DB_CYCLES+3 rising edges from the first edge sampling a changed, thereafter steady raw input to the resulting strobe or level change.
REQ-021 SHALL produce no output change from a glitch shorter than DB_CYCLES cycles after synchronization.

Reset
REQ-022 SHALL clear everything while rst is high: synchronizers, counters, stable values (kbd 0, buttons released, door open) and key lock. Outputs go to digit=0, digit_valid=0, all pulses 0, door_closed_db=0.
REQ-023 SHALL abort any partial debounce count on reset mid-operation.
REQ-024 SHALL, when an input is held active across reset deassertion, produce exactly one strobe (or door_closed_db=1) DB_CYCLES+3 edges after the first non-reset edge.

Configuration
REQ-025 SHALL support macro KBD_MULTI_KEY_REJECT_EN. When defined, a zero-to-nonzero stable vector that is not one-hot produces no digit_valid, and the path still locks until all-zero.
REQ-026 SHALL, when KBD_MULTI_KEY_REJECT_EN is undefined, encode the lowest-index set bit of a multi-key vector and strobe it.

Structure
REQ-027 SHALL import constants from shared package mw_pkg: KEY_COUNT=10, DIGIT_W=4, DB_CYCLES_DEFAULT=4.
REQ-028 SHALL implement synchronizer and debounce as sub-module debounce, with a WIDTH parameter. It is instantiated for kbd (WIDTH=10) and for each button and the door (WIDTH=1).

Verification (DB_CYCLES=4)
REQ-029 SHALL cover: kbd=10'b0000000010 held 20 cycles -> digit=1, one digit_valid at edge 7, none more until release.
REQ-030 SHALL cover: startn low 2 cycles then high -> no start_pulse; startn low 10 cycles -> exactly one start_pulse at edge 7.
REQ-031 SHALL cover: startn and stopn asserted on the same edge and held -> stop_pulse only, start_pulse stays 0.
REQ-032 SHALL cover: kbd=10'b1000000100 -> with macro, no digit_valid; without macro, digit=2 strobed once.
REQ-033 SHALL cover: door_closed toggles 1/0 every cycle for 20 cycles then held 1 -> door_closed_db 0 throughout the toggling, 1 after 7 steady edges.
REQ-034 SHALL cover: rst asserted at debounce count 3 with key 9 held, released next cycle -> all outputs 0 during reset, one digit_valid with digit=9 seven edges after release.
